// File: rtl/ssd_pkg.sv
// ssd_pkg: shared encodings for the seven-segment display scheduler.
package ssd_pkg;
  localparam int DIGIT_COUNT = 8;
  localparam int BCD_CYCLES = 16;
  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;
  localparam logic [7:0] ANODE [DIGIT_COUNT] = '{
    8'b0111_1111, 8'b1011_1111, 8'b1101_1111, 8'b1110_1111,
    8'b1111_0111, 8'b1111_1011, 8'b1111_1101, 8'b1111_1110
  };
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd1: return 7'b100_1111;
      4'd2: return 7'b001_0010;
      4'd3: return 7'b000_0110;
      4'd4: return 7'b100_1100;
      4'd5: return 7'b010_0100;
      4'd6: return 7'b010_0000;
      4'd7: return 7'b000_1111;
      4'd8: return 7'b000_0000;
      4'd9: return 7'b000_0100;
      default: return 7'b000_0001;
    endcase
  endfunction
  function automatic logic [7:0] split10(input logic [3:0] v);
    return (v >= 4'd10) ? {4'd1, v - 4'd10} : {4'd0, v};
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 16-cycle shift-add-3 conversion of a 14-bit value into four BCD nibbles.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);
  logic [15:0] r_sh;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_run;
  logic        r_done;
  logic [15:0] w_adj;
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign w_adj[4*g+:4] = (r_bcd[4*g+:4] >= 4'd5) ? r_bcd[4*g+:4] + 4'd3 : r_bcd[4*g+:4];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_sh <= {2'b00, bin};
        r_bcd <= '0;
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_bcd <= 16'({w_adj, r_sh[15]});
        r_sh <= {r_sh[14:0], 1'b0};
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'(BCD_CYCLES - 1)) begin
          r_run <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end
  assign done = r_done;
  assign bcd = r_bcd;
endmodule

// File: rtl/ssd_display_scheduler.sv
// ssd_display_scheduler: captures score/power/angle, converts to BCD, commits atomically
// and multiplexes the eight active-low digits.
module ssd_display_scheduler
  import ssd_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int SCORE_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score_in,
  input  logic [3:0]  power_in,
  input  logic [3:0]  angle_in,
  input  logic        update_req,
  input  logic        blank_en,
  output logic        busy,
  output logic        update_ack,
  output logic [7:0]  anode,
  output logic [6:0]  ssd_out
);
  state_t                  r_state;
  logic                    r_pending;
  logic                    r_busy;
  logic                    r_ack;
  logic [3:0]              r_pow;
  logic [3:0]              r_ang;
  logic [3:0]              r_dig [DIGIT_COUNT];
  logic [REFRESH_BITS-1:0] r_pre;
  logic [2:0]              r_idx;
  logic [7:0]              r_anode;
  logic [6:0]              r_seg;
  logic                    w_start;
  logic [13:0]             w_bin;
  logic                    w_done;
  logic [15:0]             w_bcd;
  logic [3:0]              w_cur;
  logic [2:0]              w_z;
  logic [3:0]              w_lz;
  logic                    w_blank;
  assign w_start = (r_state == S_IDLE) && (update_req || r_pending);
  assign w_bin = (score_in > 16'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_in[13:0];
  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (w_bin),
    .done  (w_done),
    .bcd   (w_bcd)
  );
  // Conversion finishes into the sub-module; digits only change on the done edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pending <= 1'b0;
      r_busy <= 1'b0;
      r_ack <= 1'b0;
      r_pow <= '0;
      r_ang <= '0;
      for (int i = 0; i < DIGIT_COUNT; i++) r_dig[i] <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_pow <= power_in;
          r_ang <= angle_in;
          r_pending <= 1'b0;
          r_busy <= 1'b1;
          r_state <= S_CONVERT;
        end
        S_CONVERT: begin
          if (update_req) r_pending <= 1'b1;
          if (w_done) begin
            r_dig[0] <= w_bcd[15:12];
            r_dig[1] <= w_bcd[11:8];
            r_dig[2] <= w_bcd[7:4];
            r_dig[3] <= w_bcd[3:0];
            {r_dig[4], r_dig[5]} <= split10(r_pow);
            {r_dig[6], r_dig[7]} <= split10(r_ang);
            r_ack <= 1'b1;
            r_state <= S_COMMIT;
          end
        end
        default: begin
          if (update_req) r_pending <= 1'b1;
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign w_cur = r_dig[r_idx];
  assign w_z = {r_dig[2] == 4'd0, r_dig[1] == 4'd0, r_dig[0] == 4'd0};
  assign w_lz = {1'b0, &w_z, &w_z[1:0], w_z[0]};
  assign w_blank = (blank_en && !r_idx[2] && w_lz[r_idx[1:0]]) ||
                   ((r_idx == 3'd4 || r_idx == 3'd6) && w_cur == 4'd0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_anode <= 8'hFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (&r_pre) r_idx <= r_idx + 3'd1;
      r_anode <= ANODE[r_idx];
      r_seg <= w_blank ? SEG_BLANK : seg_of(w_cur);
    end
  end
  assign busy = r_busy;
  assign update_ack = r_ack;
  assign anode = r_anode;
  assign ssd_out = r_seg;
endmodule
